// File: rtl/window_extrema_tracker_pkg.sv
// rtl/window_extrema_tracker_pkg.sv - shared constants and state encoding for window_extrema_tracker
package window_extrema_tracker_pkg;

   localparam int WIDTH = 8;

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_TRACK  = 2'd1,
      ST_REPORT = 2'd2
   } state_t;

endpackage

// File: rtl/eight_bit_comparator.sv
// rtl/eight_bit_comparator.sv - unsigned 8-bit magnitude comparator
module eight_bit_comparator (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic       gt,
   output logic       eq,
   output logic       lt
);

   assign gt = (a > b);
   assign eq = (a == b);
   assign lt = (a < b);

endmodule

// File: rtl/window_extrema_tracker.sv
// rtl/window_extrema_tracker.sv - per-window max/min tracker with first-occurrence indices
module window_extrema_tracker #(
   parameter int WIDTH  = 8,
   parameter int WINDOW = 8,
   parameter int IDX_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_max,
   output logic [WIDTH-1:0] res_min,
   output logic [IDX_W-1:0] res_max_idx,
   output logic [IDX_W-1:0] res_min_idx
);

   import window_extrema_tracker_pkg::*;

   // The comparator is fixed at 8 bits, so any other sample width cannot be built.
   if (WIDTH != window_extrema_tracker_pkg::WIDTH) begin : g_bad_width
      $error("window_extrema_tracker: WIDTH must be 8");
   end
   if ((WINDOW < 1) || (WINDOW > 255)) begin : g_bad_window
      $error("window_extrema_tracker: WINDOW must be 1..255");
   end
   if ((64'd1 << IDX_W) < 64'(WINDOW)) begin : g_bad_idx_w
      $error("window_extrema_tracker: IDX_W too narrow for WINDOW");
   end

   // One extra bit so the counter can reach WINDOW without wrapping.
   localparam logic [IDX_W:0] LAST_CNT = (IDX_W + 1)'(WINDOW - 1);
   localparam logic [IDX_W:0] ONE_CNT  = (IDX_W + 1)'(1);

   state_t           state_q;
   state_t           state_d;
   logic [IDX_W:0]   count_q;
   logic             accept;
   logic             last_sample;
   logic [WIDTH-1:0] cmp_sample;
   logic             max_gt;
   logic             max_eq;
   logic             max_lt;
   logic             min_gt;
   logic             min_eq;
   logic             min_lt;
   logic             unused_cmp_flags;

   assign in_ready    = rst_n && !clear && (state_q != ST_REPORT);
   assign accept      = in_valid && in_ready;
   assign last_sample = (count_q == LAST_CNT);

   // Zero the comparator operand when nothing is taken so an undriven bus stays contained.
   assign cmp_sample = accept ? in_data : '0;

   eight_bit_comparator cmp_max (
      .a  (cmp_sample),
      .b  (res_max),
      .gt (max_gt),
      .eq (max_eq),
      .lt (max_lt)
   );

   eight_bit_comparator cmp_min (
      .a  (cmp_sample),
      .b  (res_min),
      .gt (min_gt),
      .eq (min_eq),
      .lt (min_lt)
   );

   // Only "greater" from cmp_max and "lower" from cmp_min drive updates; equal keeps the first occurrence.
   assign unused_cmp_flags = ^{max_eq, max_lt, min_gt, min_eq};

   // State register; res_valid is registered alongside so it tracks REPORT exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_EMPTY;
         res_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         res_valid <= (state_d == ST_REPORT);
      end
   end

   // Next-state decode; clear overrides every other transition.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d = (WINDOW == 1) ? ST_REPORT : ST_TRACK;
            end
         end
         ST_TRACK: begin
            if (accept && last_sample) begin
               state_d = ST_REPORT;
            end
         end
         ST_REPORT: begin
            if (res_ready) begin
               state_d = ST_EMPTY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (clear) begin
         state_d = ST_EMPTY;
      end
   end

   // Sample counter and running extrema; results persist until the next window's first sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q     <= '0;
         res_max     <= '0;
         res_min     <= '0;
         res_max_idx <= '0;
         res_min_idx <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (accept) begin
         if (state_q == ST_EMPTY) begin
            res_max     <= in_data;
            res_min     <= in_data;
            res_max_idx <= '0;
            res_min_idx <= '0;
            count_q     <= ONE_CNT;
         end else begin
            if (max_gt) begin
               res_max     <= in_data;
               res_max_idx <= count_q[IDX_W-1:0];
            end
            if (min_lt) begin
               res_min     <= in_data;
               res_min_idx <= count_q[IDX_W-1:0];
            end
            count_q <= count_q + 1'b1;
         end
      end else if ((state_q == ST_REPORT) && res_ready) begin
         count_q <= '0;
      end
   end

endmodule

// File: tb/tb_window_extrema_tracker.sv
// tb/tb_window_extrema_tracker.sv - directed self-checking bench for window_extrema_tracker
module tb_window_extrema_tracker;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   logic       clear8, in_valid8, in_ready8, res_valid8, res_ready8;
   logic [7:0] in_data8, res_max8, res_min8, res_max_idx8, res_min_idx8;
   logic       clear4, in_valid4, in_ready4, res_valid4, res_ready4;
   logic [7:0] in_data4, res_max4, res_min4, res_max_idx4, res_min_idx4;
   logic       clear1, in_valid1, in_ready1, res_valid1, res_ready1;
   logic [7:0] in_data1, res_max1, res_min1, res_max_idx1, res_min_idx1;

   window_extrema_tracker #(.WIDTH(8), .WINDOW(8), .IDX_W(8)) u8 (
      .clk(clk), .rst_n(rst_n), .clear(clear8), .in_valid(in_valid8), .in_data(in_data8),
      .in_ready(in_ready8), .res_valid(res_valid8), .res_ready(res_ready8),
      .res_max(res_max8), .res_min(res_min8), .res_max_idx(res_max_idx8), .res_min_idx(res_min_idx8)
   );

   window_extrema_tracker #(.WIDTH(8), .WINDOW(4), .IDX_W(8)) u4 (
      .clk(clk), .rst_n(rst_n), .clear(clear4), .in_valid(in_valid4), .in_data(in_data4),
      .in_ready(in_ready4), .res_valid(res_valid4), .res_ready(res_ready4),
      .res_max(res_max4), .res_min(res_min4), .res_max_idx(res_max_idx4), .res_min_idx(res_min_idx4)
   );

   window_extrema_tracker #(.WIDTH(8), .WINDOW(1), .IDX_W(8)) u1 (
      .clk(clk), .rst_n(rst_n), .clear(clear1), .in_valid(in_valid1), .in_data(in_data1),
      .in_ready(in_ready1), .res_valid(res_valid1), .res_ready(res_ready1),
      .res_max(res_max1), .res_min(res_min1), .res_max_idx(res_max_idx1), .res_min_idx(res_min_idx1)
   );

   task automatic test_reset();
      rst_n = 1'b0;
      clear8 = 0; in_valid8 = 0; in_data8 = 0; res_ready8 = 0;
      clear4 = 0; in_valid4 = 0; in_data4 = 0; res_ready4 = 0;
      clear1 = 0; in_valid1 = 0; in_data1 = 0; res_ready1 = 0;
      repeat (2) @(negedge clk);
      total++; if (in_ready8 !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0h want=0", in_ready8); end
      total++; if (res_valid8 !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%0h want=0", res_valid8); end
      total++; if (res_max8 !== 8'h00) begin bad++; $display("FAIL rst_res_max got=%0h want=0", res_max8); end
      total++; if (res_min8 !== 8'h00) begin bad++; $display("FAIL rst_res_min got=%0h want=0", res_min8); end
      total++; if (res_max_idx8 !== 8'h00) begin bad++; $display("FAIL rst_max_idx got=%0h want=0", res_max_idx8); end
      total++; if (res_min_idx8 !== 8'h00) begin bad++; $display("FAIL rst_min_idx got=%0h want=0", res_min_idx8); end
      rst_n = 1'b1;
      #1;
      total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%0h want=1", in_ready8); end
   endtask

   task automatic test_stream8();
      logic [7:0] s [8] = '{8'h05, 8'h80, 8'h03, 8'h80, 8'hFF, 8'h00, 8'hFF, 8'h00};
      res_ready8 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid8 = 1'b1; in_data8 = s[i];
         @(negedge clk);
      end
      in_valid8 = 1'b0;
      total++; if (res_valid8 !== 1'b1) begin bad++; $display("FAIL s8_valid got=%0h want=1", res_valid8); end
      total++; if (in_ready8 !== 1'b0) begin bad++; $display("FAIL s8_in_ready got=%0h want=0", in_ready8); end
      total++; if (res_max8 !== 8'hFF) begin bad++; $display("FAIL s8_max got=%0h want=ff", res_max8); end
      total++; if (res_max_idx8 !== 8'd4) begin bad++; $display("FAIL s8_max_idx got=%0d want=4", res_max_idx8); end
      total++; if (res_min8 !== 8'h00) begin bad++; $display("FAIL s8_min got=%0h want=0", res_min8); end
      total++; if (res_min_idx8 !== 8'd5) begin bad++; $display("FAIL s8_min_idx got=%0d want=5", res_min_idx8); end
      @(negedge clk);
      total++; if (res_valid8 !== 1'b0) begin bad++; $display("FAIL s8_valid_drop got=%0h want=0", res_valid8); end
   endtask

   task automatic test_hold4();
      logic [7:0] s [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
      res_ready4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid4 = 1'b1; in_data4 = s[i];
         @(negedge clk);
      end
      in_data4 = 8'h99;
      for (int c = 0; c < 5; c++) begin
         total++; if (res_valid4 !== 1'b1) begin bad++; $display("FAIL hold_valid c=%0d got=%0h want=1", c, res_valid4); end
         total++; if (in_ready4 !== 1'b0) begin bad++; $display("FAIL hold_in_ready c=%0d got=%0h want=0", c, in_ready4); end
         total++; if (res_max4 !== 8'h08) begin bad++; $display("FAIL hold_max c=%0d got=%0h want=8", c, res_max4); end
         total++; if (res_max_idx4 !== 8'd3) begin bad++; $display("FAIL hold_max_idx c=%0d got=%0d want=3", c, res_max_idx4); end
         total++; if (res_min4 !== 8'h01) begin bad++; $display("FAIL hold_min c=%0d got=%0h want=1", c, res_min4); end
         total++; if (res_min_idx4 !== 8'd0) begin bad++; $display("FAIL hold_min_idx c=%0d got=%0d want=0", c, res_min_idx4); end
         @(negedge clk);
      end
      in_valid4 = 1'b0;
      res_ready4 = 1'b1;
      total++; if (res_valid4 !== 1'b1) begin bad++; $display("FAIL hold_valid_hs got=%0h want=1", res_valid4); end
      @(negedge clk);
      total++; if (res_valid4 !== 1'b0) begin bad++; $display("FAIL hold_valid_drop got=%0h want=0", res_valid4); end
      total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL hold_ready_back got=%0h want=1", in_ready4); end
   endtask

   task automatic test_gaps4(input int gap);
      res_ready4 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid4 = 1'b1; in_data4 = 8'h7F;
         @(negedge clk);
         in_valid4 = 1'b0; in_data4 = 8'hxx;
         if (i < 3) repeat (gap) @(negedge clk);
      end
      total++; if (res_valid4 !== 1'b1) begin bad++; $display("FAIL gap%0d_valid got=%0h want=1", gap, res_valid4); end
      total++; if (res_max4 !== 8'h7F) begin bad++; $display("FAIL gap%0d_max got=%0h want=7f", gap, res_max4); end
      total++; if (res_min4 !== 8'h7F) begin bad++; $display("FAIL gap%0d_min got=%0h want=7f", gap, res_min4); end
      total++; if (res_max_idx4 !== 8'd0) begin bad++; $display("FAIL gap%0d_max_idx got=%0d want=0", gap, res_max_idx4); end
      total++; if (res_min_idx4 !== 8'd0) begin bad++; $display("FAIL gap%0d_min_idx got=%0d want=0", gap, res_min_idx4); end
      @(negedge clk);
      total++; if (res_valid4 !== 1'b0) begin bad++; $display("FAIL gap%0d_valid_drop got=%0h want=0", gap, res_valid4); end
   endtask

   task automatic test_clear8();
      logic [7:0] a [3] = '{8'h11, 8'h22, 8'h33};
      res_ready8 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid8 = 1'b1; in_data8 = a[i];
         @(negedge clk);
      end
      clear8 = 1'b1; in_valid8 = 1'b1; in_data8 = 8'h01;
      #1;
      total++; if (in_ready8 !== 1'b0) begin bad++; $display("FAIL clr_in_ready got=%0h want=0", in_ready8); end
      @(negedge clk);
      clear8 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_valid8 = 1'b1; in_data8 = 8'((i + 1) * 16);
         @(negedge clk);
      end
      in_valid8 = 1'b0;
      total++; if (res_valid8 !== 1'b1) begin bad++; $display("FAIL clr_valid got=%0h want=1", res_valid8); end
      total++; if (res_max8 !== 8'h80) begin bad++; $display("FAIL clr_max got=%0h want=80", res_max8); end
      total++; if (res_max_idx8 !== 8'd7) begin bad++; $display("FAIL clr_max_idx got=%0d want=7", res_max_idx8); end
      total++; if (res_min8 !== 8'h10) begin bad++; $display("FAIL clr_min got=%0h want=10", res_min8); end
      total++; if (res_min_idx8 !== 8'd0) begin bad++; $display("FAIL clr_min_idx got=%0d want=0", res_min_idx8); end
      @(negedge clk);
      total++; if (res_valid8 !== 1'b0) begin bad++; $display("FAIL clr_valid_drop got=%0h want=0", res_valid8); end
   endtask

   task automatic test_async_reset();
      logic [7:0] s [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
      logic [7:0] t [4] = '{8'h09, 8'h03, 8'h0C, 8'h05};
      res_ready4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid4 = 1'b1; in_data4 = s[i];
         @(negedge clk);
      end
      in_valid4 = 1'b0;
      total++; if (res_valid4 !== 1'b1) begin bad++; $display("FAIL ar_pre_valid got=%0h want=1", res_valid4); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (res_valid4 !== 1'b0) begin bad++; $display("FAIL ar_valid got=%0h want=0", res_valid4); end
      total++; if (res_max4 !== 8'h00) begin bad++; $display("FAIL ar_max got=%0h want=0", res_max4); end
      total++; if (res_min4 !== 8'h00) begin bad++; $display("FAIL ar_min got=%0h want=0", res_min4); end
      total++; if (res_max_idx4 !== 8'd0) begin bad++; $display("FAIL ar_max_idx got=%0d want=0", res_max_idx4); end
      total++; if (res_min_idx4 !== 8'd0) begin bad++; $display("FAIL ar_min_idx got=%0d want=0", res_min_idx4); end
      total++; if (in_ready4 !== 1'b0) begin bad++; $display("FAIL ar_in_ready got=%0h want=0", in_ready4); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL ar_release_ready got=%0h want=1", in_ready4); end
      res_ready4 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid4 = 1'b1; in_data4 = t[i];
         @(negedge clk);
      end
      in_valid4 = 1'b0;
      total++; if (res_valid4 !== 1'b1) begin bad++; $display("FAIL ar_new_valid got=%0h want=1", res_valid4); end
      total++; if (res_max4 !== 8'h0C) begin bad++; $display("FAIL ar_new_max got=%0h want=c", res_max4); end
      total++; if (res_max_idx4 !== 8'd2) begin bad++; $display("FAIL ar_new_max_idx got=%0d want=2", res_max_idx4); end
      total++; if (res_min4 !== 8'h03) begin bad++; $display("FAIL ar_new_min got=%0h want=3", res_min4); end
      total++; if (res_min_idx4 !== 8'd1) begin bad++; $display("FAIL ar_new_min_idx got=%0d want=1", res_min_idx4); end
      @(negedge clk);
   endtask

   task automatic test_window1();
      res_ready1 = 1'b1;
      in_valid1 = 1'b1; in_data1 = 8'hAA;
      @(negedge clk);
      in_data1 = 8'h55;
      total++; if (res_valid1 !== 1'b1) begin bad++; $display("FAIL w1a_valid got=%0h want=1", res_valid1); end
      total++; if (in_ready1 !== 1'b0) begin bad++; $display("FAIL w1a_in_ready got=%0h want=0", in_ready1); end
      total++; if (res_max1 !== 8'hAA) begin bad++; $display("FAIL w1a_max got=%0h want=aa", res_max1); end
      total++; if (res_min1 !== 8'hAA) begin bad++; $display("FAIL w1a_min got=%0h want=aa", res_min1); end
      total++; if ((res_max_idx1 | res_min_idx1) !== 8'd0) begin bad++; $display("FAIL w1a_idx got=%0d/%0d want=0/0", res_max_idx1, res_min_idx1); end
      @(negedge clk);
      total++; if (res_valid1 !== 1'b0) begin bad++; $display("FAIL w1_gap_valid got=%0h want=0", res_valid1); end
      total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL w1_gap_in_ready got=%0h want=1", in_ready1); end
      @(negedge clk);
      in_valid1 = 1'b0;
      total++; if (res_valid1 !== 1'b1) begin bad++; $display("FAIL w1b_valid got=%0h want=1", res_valid1); end
      total++; if (in_ready1 !== 1'b0) begin bad++; $display("FAIL w1b_in_ready got=%0h want=0", in_ready1); end
      total++; if (res_max1 !== 8'h55) begin bad++; $display("FAIL w1b_max got=%0h want=55", res_max1); end
      total++; if (res_min1 !== 8'h55) begin bad++; $display("FAIL w1b_min got=%0h want=55", res_min1); end
      total++; if ((res_max_idx1 | res_min_idx1) !== 8'd0) begin bad++; $display("FAIL w1b_idx got=%0d/%0d want=0/0", res_max_idx1, res_min_idx1); end
      @(negedge clk);
      total++; if (res_valid1 !== 1'b0) begin bad++; $display("FAIL w1b_valid_drop got=%0h want=0", res_valid1); end
   endtask

   initial begin
      test_reset();
      test_stream8();
      test_hold4();
      test_gaps4(0);
      test_gaps4(2);
      test_clear8();
      test_async_reset();
      test_window1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
